// File: rtl/fetch_pkg.sv
// fetch_pkg: shared thread-id types and helpers for the fetch scheduler
package fetch_pkg;
  localparam int THREAD_W = 2;
  localparam int NUM_THREADS = 1 << THREAD_W;
  typedef logic [THREAD_W-1:0] tid_t;
  function automatic logic [31:0] thread_base_pc(input int aw, input tid_t t);
    return 32'(t) << (aw - THREAD_W);
  endfunction
  function automatic logic [NUM_THREADS-1:0] onehot(input tid_t id);
    return NUM_THREADS'(1) << id;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin first-set finder starting at rr_ptr
module rr_pick
  import fetch_pkg::*;
(
  input  logic [NUM_THREADS-1:0] elig,
  input  logic [THREAD_W-1:0]    rr_ptr,
  output logic [THREAD_W-1:0]    sel,
  output logic                   any
);
  // scan from the farthest offset down so the nearest eligible thread wins
  always_comb begin
    sel = rr_ptr;
    any = |elig;
    for (int i = NUM_THREADS - 1; i >= 0; i--)
      if (elig[rr_ptr + THREAD_W'(i)]) sel = rr_ptr + THREAD_W'(i);
  end
endmodule

// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched: per-thread PCs with round-robin fetch feeding IF/ID
module thread_fetch_sched
  import fetch_pkg::*;
#(
  parameter int INSTMEM_LOG2_DEEP = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         hazard,
  input  logic                         br_valid,
  input  logic [THREAD_W-1:0]          br_thread_id,
  input  logic [INSTMEM_LOG2_DEEP-1:0] br_target,
  input  logic                         halt_valid,
  input  logic [THREAD_W-1:0]          halt_thread_id,
  input  logic                         start_valid,
  input  logic [THREAD_W-1:0]          start_thread_id,
  input  logic [INSTMEM_LOG2_DEEP-1:0] start_pc,
  output logic [INSTMEM_LOG2_DEEP-1:0] PC_out,
  output logic [THREAD_W-1:0]          thread_id_out,
  output logic                         wb_ff_out,
  output logic [NUM_THREADS-1:0]       active_mask,
  output logic                         all_halted
);
  logic [INSTMEM_LOG2_DEEP-1:0] pc [NUM_THREADS];
  logic [THREAD_W-1:0]          rr_ptr, sel;
  logic                         any, fetch;
  logic [NUM_THREADS-1:0]       halt_oh, start_oh, elig, act_nxt;
  // a thread halted this cycle is already excluded from selection
  always_comb begin
    halt_oh = halt_valid ? onehot(halt_thread_id) : '0;
    start_oh = start_valid ? onehot(start_thread_id) : '0;
    elig = active_mask & ~halt_oh;
    act_nxt = (active_mask | start_oh) & ~halt_oh;
    fetch = !hazard && any;
  end
  rr_pick u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any    (any)
  );
  // per-thread PC: start beats redirect beats fetch increment
  always_ff @(posedge CLK) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (RST) pc[t] <= INSTMEM_LOG2_DEEP'(thread_base_pc(INSTMEM_LOG2_DEEP, THREAD_W'(t)));
      else if (start_valid && start_thread_id == THREAD_W'(t)) pc[t] <= start_pc;
      else if (br_valid && br_thread_id == THREAD_W'(t)) pc[t] <= br_target;
      else if (fetch && sel == THREAD_W'(t)) pc[t] <= pc[t] + 1'b1;
    end
  end
  // active bits, round-robin pointer and the IF/ID-facing output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      active_mask <= '1;
      all_halted <= 1'b0;
      rr_ptr <= '0;
      PC_out <= '0;
      thread_id_out <= '0;
      wb_ff_out <= 1'b0;
    end else begin
      active_mask <= act_nxt;
      all_halted <= act_nxt == '0;
      if (!hazard) wb_ff_out <= any;
      if (fetch) begin
        PC_out <= pc[sel];
        thread_id_out <= sel;
        rr_ptr <= sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_thread_fetch_sched.sv
// tb_thread_fetch_sched: randomized and directed checks against a behavioural model
module tb_thread_fetch_sched;
  logic       CLK = 0;
  logic       RST, hazard, br_valid, halt_valid, start_valid;
  logic [1:0] br_thread_id, halt_thread_id, start_thread_id;
  logic [7:0] br_target, start_pc;
  logic [7:0] PC_out;
  logic [1:0] thread_id_out;
  logic       wb_ff_out, all_halted;
  logic [3:0] active_mask;

  int n_chk = 0, n_pass = 0;
  int m_pc [4];
  int m_act [4];
  int m_rr, o_pc, o_tid, o_wb;

  thread_fetch_sched #(.INSTMEM_LOG2_DEEP(8)) dut (
    .CLK(CLK), .RST(RST), .hazard(hazard),
    .br_valid(br_valid), .br_thread_id(br_thread_id), .br_target(br_target),
    .halt_valid(halt_valid), .halt_thread_id(halt_thread_id),
    .start_valid(start_valid), .start_thread_id(start_thread_id), .start_pc(start_pc),
    .PC_out(PC_out), .thread_id_out(thread_id_out), .wb_ff_out(wb_ff_out),
    .active_mask(active_mask), .all_halted(all_halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int pick();
    for (int k = 0; k < 4; k++) begin
      int t = (m_rr + k) % 4;
      if (m_act[t] != 0 && !(halt_valid && int'(halt_thread_id) == t)) return t;
    end
    return -1;
  endfunction

  function automatic int mask_val();
    int m = 0;
    for (int t = 0; t < 4; t++) if (m_act[t] != 0) m += (1 << t);
    return m;
  endfunction

  task automatic model_clock();
    if (RST) begin
      for (int t = 0; t < 4; t++) begin
        m_pc[t] = t * 64;
        m_act[t] = 1;
      end
      m_rr = 0; o_pc = 0; o_tid = 0; o_wb = 0;
    end else begin
      int s = pick();
      if (!hazard) begin
        if (s >= 0) begin
          o_pc = m_pc[s]; o_tid = s; o_wb = 1;
          m_rr = (s + 1) % 4;
          m_pc[s] = (m_pc[s] + 1) % 256;
        end else o_wb = 0;
      end
      if (br_valid) m_pc[br_thread_id] = br_target;
      if (start_valid) begin
        m_pc[start_thread_id] = start_pc;
        m_act[start_thread_id] = 1;
      end
      if (halt_valid) m_act[halt_thread_id] = 0;
    end
  endtask

  task automatic idle();
    RST = 0; hazard = 0; br_valid = 0; halt_valid = 0; start_valid = 0;
    br_thread_id = 0; halt_thread_id = 0; start_thread_id = 0;
    br_target = 0; start_pc = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    model_clock();
    #1;
    chk("pc_out", int'(PC_out), o_pc);
    chk("thread_id", int'(thread_id_out), o_tid);
    chk("wb_ff", int'(wb_ff_out), o_wb);
    chk("active_mask", int'(active_mask), mask_val());
    chk("all_halted", int'(all_halted), int'(mask_val() == 0));
    idle();
  endtask

  task automatic free_run_table();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("seq_tid", int'(thread_id_out), i % 4);
      chk("seq_pc", int'(PC_out), (i % 4) * 64 + i / 4);
      chk("seq_wb", int'(wb_ff_out), 1);
    end
  endtask

  initial begin
    bit done;
    idle();
    RST = 1;
    step();
    chk("rst_pc", int'(PC_out), 0);
    chk("rst_mask", int'(active_mask), 15);
    chk("rst_wb", int'(wb_ff_out), 0);
    free_run_table();
    step(); step();
    for (int i = 0; i < 3; i++) begin
      hazard = 1; step();
      chk("hz_hold_pc", int'(PC_out), 66);
    end
    step();
    chk("hz_release_pc", int'(PC_out), 130);
    step(); step();
    halt_valid = 1; halt_thread_id = 1; step();
    chk("halt_skip_tid", int'(thread_id_out), 2);
    for (int i = 0; i < 4; i++) step();
    chk("halt_mask", int'(active_mask), 13);
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (pick() == 2) begin
        br_valid = 1; br_thread_id = 2; br_target = 8'h50; done = 1;
      end
      step();
    end
    chk("br_window", int'(done), 1);
    for (int i = 0; i < 6; i++) step();
    halt_valid = 1; halt_thread_id = 3; step();
    step(); step();
    start_valid = 1; start_thread_id = 3; start_pc = 8'hFF; step();
    for (int i = 0; i < 8; i++) step();
    for (int t = 0; t < 4; t++) begin
      halt_valid = 1; halt_thread_id = 2'(t); step();
    end
    for (int i = 0; i < 3; i++) step();
    chk("all_halt_flag", int'(all_halted), 1);
    chk("all_halt_wb", int'(wb_ff_out), 0);
    RST = 1; hazard = 1; br_valid = 1; br_thread_id = 0; br_target = 8'h33;
    start_valid = 1; start_thread_id = 0; start_pc = 8'h77;
    step();
    free_run_table();
    for (int i = 0; i < 2000; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      hazard = ($urandom_range(0, 4) == 0);
      br_valid = ($urandom_range(0, 4) == 0);
      br_thread_id = 2'($urandom_range(0, 3));
      br_target = 8'($urandom);
      halt_valid = ($urandom_range(0, 9) == 0);
      halt_thread_id = 2'($urandom_range(0, 3));
      start_valid = ($urandom_range(0, 6) == 0);
      start_thread_id = 2'($urandom_range(0, 3));
      start_pc = 8'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/thread_fetch_sched.md
Name: thread_fetch_sched

Overview:
- Fetch-side producer for the IF/ID stage register in the 4-thread barrel pipeline.
- Holds one PC per hardware thread and picks the next active thread round-robin each cycle.
- Presents PC, thread id and a fetch-valid flag to IF/ID (PC_in, thread_id_in, wb_ff_in).
- Applies per-thread branch redirects, halts and starts; freezes completely on hazard.

Parameters:
- INSTMEM_LOG2_DEEP, 8: PC width; instruction memory depth 2^INSTMEM_LOG2_DEEP.
- THREAD_W, 2: thread id width; NUM_THREADS = 2^THREAD_W = 4.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- hazard  in  1  stall from hazard unit; freezes fetch.
- br_valid  in  1  redirect request.
- br_thread_id  in  THREAD_W  thread to redirect.
- br_target  in  INSTMEM_LOG2_DEEP  new PC.
- halt_valid  in  1  halt request.
- halt_thread_id  in  THREAD_W  thread to deactivate.
- start_valid  in  1  start request.
- start_thread_id  in  THREAD_W  thread to activate.
- start_pc  in  INSTMEM_LOG2_DEEP  PC for the started thread.
- PC_out  out  INSTMEM_LOG2_DEEP  fetch PC, to IF/ID PC_in.
- thread_id_out  out  THREAD_W  fetched thread, to IF/ID thread_id_in.
- wb_ff_out  out  1  1 = real fetch, 0 = bubble; to IF/ID wb_ff_in.
- active_mask  out  NUM_THREADS  registered per-thread active bits.
- all_halted  out  1  active_mask == 0.

Behaviour:
- Reset:
  - pc[t] = t << (INSTMEM_LOG2_DEEP-THREAD_W); for defaults, bases are 0, 64, 128, 192.
  - active_mask = all ones; rr_ptr = 0.
  - PC_out = 0, thread_id_out = 0, wb_ff_out = 0, all_halted = 0.
  - Reset overrides every request in the same cycle, including mid-operation.
- Eligibility, combinational: elig = active_mask & ~(halt_valid ? onehot(halt_thread_id) : 0). A thread halted this cycle is not fetched this cycle.
- Selection: first set bit of elig, searching rr_ptr, rr_ptr+1, ... modulo NUM_THREADS.
- Normal cycle (hazard = 0, elig != 0), registered outputs, 1-cycle latency:
  - PC_out <= pc[sel]; thread_id_out <= sel; wb_ff_out <= 1.
  - pc[sel] <= pc[sel]+1, wrapping modulo 2^INSTMEM_LOG2_DEEP (255 -> 0).
  - rr_ptr <= sel+1 (mod NUM_THREADS).
- No eligible thread (hazard = 0, elig == 0): wb_ff_out <= 0; PC_out, thread_id_out and rr_ptr hold.
- hazard = 1:
  - PC_out, thread_id_out, wb_ff_out and rr_ptr hold; no PC increment.
  - Redirect, halt and start requests are still applied to pc[] and active_mask.
- Redirect: pc[br_thread_id] <= br_target. If that thread is selected in the same cycle, the redirect overrides the +1 increment; the output still carries the old PC. Squashing in-flight instructions is done downstream.
- Start: active[start_thread_id] <= 1; pc[start_thread_id] <= start_pc. The thread becomes eligible the next cycle.
- Priority on the same thread in the same cycle:
  - PC write: start_pc > br_target > increment.
  - Active bit: halt > start, i.e. the thread ends inactive, but its PC is still written.
- Requests on different threads in the same cycle are all applied.
- all_halted is registered; it reflects active_mask after the update.

Decomposition:
- Package fetch_pkg:
  - THREAD_W and NUM_THREADS localparams.
  - thread-id type.
  - Function thread_base_pc(t).
  - Function onehot(id).
- Sub-module rr_pick: combinational round-robin first-set finder.
  - Inputs: elig[NUM_THREADS], rr_ptr.
  - Outputs: sel, any.
  - Reusable by the writeback arbiter.
- Top module holds the pc[] register array, active_mask, rr_ptr, output registers and the priority logic. Expected size about 150–200 lines of RTL.

Test Plan:
- Reset, then 8 free cycles, no requests -> (thread_id_out, PC_out) = (0,0), (1,64), (2,128), (3,192), (0,1), (1,65), (2,129), (3,193); wb_ff_out = 1 from the first fetch onward.
- hazard held 3 cycles after fetch (1,64) -> outputs stay (1,64,1) for 3 cycles; after release the next fetch is (2,128) with no skipped PCs.
- halt_valid for thread 1 in the same cycle thread 1 would be selected -> thread 1 is not fetched; order continues 2, 3, 0, 2; active_mask = 4'b1101.
- br_valid thread 2, target 0x50, in the cycle thread 2 is fetched at 130 -> output 130; thread 2's next fetch is 0x50, then 0x51.
- start thread 3 at PC 8'hFF (after earlier halt) -> thread 3 fetches 255, then 0 on its next turn (wraparound).
- Halt all four threads -> wb_ff_out = 0, all_halted = 1, PC_out holds. Then assert RST mid-operation -> all reset values restored and the sequence restarts at (0,0).
